// File: rtl/byte_p2s_if.sv
// Byte source / bit sink signals of the TX byte serializer.
// The master side drives bytes and the bit-rate strobe. The slave side is the serializer.
interface byte_p2s_if;
    logic       start;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       bit_en;
    logic       serial_out;
    logic       serial_en;
    logic       byte_done;
    logic       underrun;
    logic       busy;

    modport master (
        output start, data_in, data_in_valid, bit_en,
        input  data_in_ready, serial_out, serial_en, byte_done, underrun, busy
    );

    modport slave (
        input  start, data_in, data_in_valid, bit_en,
        output data_in_ready, serial_out, serial_en, byte_done, underrun, busy
    );
endinterface

// File: rtl/byte_p2s.sv
// TX byte serializer: holding register plus 8-bit shift register, MSB first,
// with one output bit per bit_en strobe.
module byte_p2s (
    input  logic       clk,
    input  logic       rst,
    byte_p2s_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_e;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       sent_any_q, sent_any_d;
    logic       sout_q, sout_d;
    logic       sen_q, sen_d;
    logic       done_q, done_d;
    logic       under_q, under_d;
    logic       ready;

    assign ready              = bus.start & ~rst & ~hold_full_q;
    assign bus.data_in_ready  = ready;
    assign bus.serial_out     = sout_q;
    assign bus.serial_en      = sen_q;
    assign bus.byte_done      = done_q;
    assign bus.underrun       = under_q;
    assign bus.busy           = (state_q == SHIFT) | hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        sent_any_d  = sent_any_q;
        sout_d      = sout_q;
        sen_d       = 1'b0;
        done_d      = 1'b0;
        under_d     = under_q;

        if (!bus.start) begin
            state_d     = IDLE;
            hold_d      = '0;
            hold_full_d = 1'b0;
            shreg_d     = '0;
            bitcnt_d    = '0;
            sent_any_d  = 1'b0;
            sout_d      = 1'b0;
            under_d     = 1'b0;
        end else begin
            // Accepting needs an empty hold and reloading needs a full one, so the two never collide.
            if (bus.data_in_valid && ready) begin
                hold_d      = bus.data_in;
                hold_full_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        bitcnt_d    = '0;
                        state_d     = SHIFT;
                    end else if (bus.bit_en && sent_any_q) begin
                        under_d = 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        sout_d   = shreg_q[7];
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 3'd1;
                        sen_d    = 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            done_d     = 1'b1;
                            sent_any_d = 1'b1;
                            if (hold_full_q) begin
                                shreg_d     = hold_q;
                                hold_full_d = 1'b0;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            sent_any_q  <= 1'b0;
            sout_q      <= 1'b0;
            sen_q       <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            sent_any_q  <= sent_any_d;
            sout_q      <= sout_d;
            sen_q       <= sen_d;
            done_q      <= done_d;
            under_q     <= under_d;
        end
    end
endmodule

// File: tb/tb_byte_p2s.sv
// Bench for byte_p2s: a queue-based reference model is compared every cycle,
// plus directed scenarios that are checked against hand-derived literals.
module tb_byte_p2s;
    logic clk = 1'b0;
    logic rst;

    byte_p2s_if bus ();

    byte_p2s dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] src_q[$];
    bit         vgate;
    int         cyc;
    int         be_per;

    // Reference model: the byte waiting in front of the shifter and the bits still to send
    logic [7:0] m_hold[$];
    bit         m_cur[$];
    bit         m_active, m_sent, m_under, m_sout, m_sen, m_done;

    logic [31:0] cap;
    int          npulse, ndone, done_at, run, maxrun, last_p, gmin, gmax;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic model_load();
        logic [7:0] b;
        b = m_hold.pop_front();
        for (int i = 7; i >= 0; i--) m_cur.push_back(b[i]);
    endtask

    task automatic model_step();
        bit empty;
        if (rst || !bus.start) begin
            m_hold.delete();
            m_cur.delete();
            m_active = 0; m_sent = 0; m_under = 0;
            m_sout = 0; m_sen = 0; m_done = 0;
        end else begin
            empty = (m_hold.size() == 0);
            m_sen = 0;
            m_done = 0;
            if (!m_active) begin
                if (!empty) begin
                    model_load();
                    m_active = 1;
                end else if (bus.bit_en && m_sent) begin
                    m_under = 1;
                end
            end else if (bus.bit_en) begin
                m_sout = m_cur.pop_front();
                m_sen = 1;
                if (m_cur.size() == 0) begin
                    m_done = 1;
                    m_sent = 1;
                    if (!empty) model_load();
                    else m_active = 0;
                end
            end
            if (empty && bus.data_in_valid) m_hold.push_back(bus.data_in);
        end
    endtask

    task automatic compare_outputs();
        bit m_ready, m_busy;
        m_ready = bus.start && !rst && (m_hold.size() == 0);
        m_busy  = m_active || (m_hold.size() != 0);
        chk("serial_en",     32'(bus.serial_en),     32'(m_sen));
        chk("serial_out",    32'(bus.serial_out),    32'(m_sout));
        chk("byte_done",     32'(bus.byte_done),     32'(m_done));
        chk("underrun",      32'(bus.underrun),      32'(m_under));
        chk("busy",          32'(bus.busy),          32'(m_busy));
        chk("data_in_ready", 32'(bus.data_in_ready), 32'(m_ready));
    endtask

    task automatic drive_be();
        if (be_per == 0) bus.bit_en = 1'($urandom_range(0, 1));
        else             bus.bit_en = ((cyc % be_per) == 0);
    endtask

    task automatic drive_src();
        bus.data_in_valid = (src_q.size() != 0) && vgate;
        bus.data_in       = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endtask

    task automatic cap_clr();
        cap = '0; npulse = 0; ndone = 0; done_at = 0;
        run = 0; maxrun = 0; last_p = -1; gmin = 1000; gmax = 0;
    endtask

    // One clock: compare and capture at the falling edge, advance the model on the rising edge
    task automatic step();
        bit acc;
        @(negedge clk);
        compare_outputs();
        if (bus.serial_en) begin
            cap = {cap[30:0], bus.serial_out};
            npulse++;
            if (last_p >= 0) begin
                if (cyc - last_p < gmin) gmin = cyc - last_p;
                if (cyc - last_p > gmax) gmax = cyc - last_p;
            end
            last_p = cyc;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
        if (bus.byte_done) begin
            ndone++;
            done_at = npulse;
        end
        acc = bus.data_in_valid && bus.data_in_ready;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (acc) void'(src_q.pop_front());
        drive_be();
        drive_src();
    endtask

    task automatic restart();
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        drive_src();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_in = '0;
        bus.data_in_valid = 1'b0;
        bus.bit_en = 1'b0;
        vgate = 1'b1;
        be_per = 1;
        cyc = 0;
        cap_clr();
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_ready",     32'(bus.data_in_ready), 32'h0);
        chk("rst_serial_en", 32'(bus.serial_en),     32'h0);
        chk("rst_underrun",  32'(bus.underrun),      32'h0);
        chk("rst_busy",      32'(bus.busy),          32'h0);
        rst = 1'b0;
        #1;
        chk("idle_ready_nostart", 32'(bus.data_in_ready), 32'h0);
        bus.start = 1'b1;
        #1;
        chk("idle_ready_start", 32'(bus.data_in_ready), 32'h1);

        // Single byte 0xA5, then strobes with no data
        cap_clr();
        be_per = 1;
        src_q.push_back(8'hA5);
        drive_src();
        drive_be();
        repeat (14) step();
        chk("a5_bits",     32'(cap[7:0]), 32'hA5);
        chk("a5_npulse",   32'(npulse),   32'd8);
        chk("a5_ndone",    32'(ndone),    32'd1);
        chk("a5_done_at",  32'(done_at),  32'd8);
        chk("a5_underrun", 32'(bus.underrun), 32'h1);
        chk("a5_busy",     32'(bus.busy),     32'h0);
        restart();
        chk("a5_underrun_clr", 32'(bus.underrun), 32'h0);

        // Back-to-back 0x3C, 0xC3
        cap_clr();
        src_q.push_back(8'h3C);
        src_q.push_back(8'hC3);
        drive_src();
        repeat (24) step();
        chk("b2b_bits",    32'(cap[15:0]), 32'h3CC3);
        chk("b2b_maxrun",  32'(maxrun),    32'd16);
        chk("b2b_ndone",   32'(ndone),     32'd2);
        chk("b2b_done_at", 32'(done_at),   32'd16);
        restart();

        // 0x81 with a strobe every 4th cycle
        cap_clr();
        be_per = 4;
        src_q.push_back(8'h81);
        drive_src();
        drive_be();
        repeat (45) step();
        chk("slow_bits",   32'(cap[7:0]), 32'h81);
        chk("slow_npulse", 32'(npulse),   32'd8);
        chk("slow_gmin",   32'(gmin),     32'd4);
        chk("slow_gmax",   32'(gmax),     32'd4);
        restart();

        // 0xFF, then starve the serializer
        cap_clr();
        be_per = 1;
        src_q.push_back(8'hFF);
        drive_src();
        drive_be();
        repeat (12) step();
        chk("ff_bits",     32'(cap[7:0]),     32'hFF);
        chk("ff_underrun", 32'(bus.underrun), 32'h1);
        repeat (5) step();
        chk("ff_sticky",   32'(bus.underrun), 32'h1);
        restart();
        chk("ff_cleared",  32'(bus.underrun), 32'h0);
        step();
        chk("ff_stays_clr", 32'(bus.underrun), 32'h0);

        // Abort 0x55 after 3 bits, then 0xAA from its MSB
        cap_clr();
        src_q.push_back(8'h55);
        drive_src();
        repeat (5) step();
        bus.start = 1'b0;
        drive_src();
        step();
        chk("abort_serial_en", 32'(bus.serial_en), 32'h0);
        chk("abort_busy",      32'(bus.busy),      32'h0);
        chk("abort_npulse",    32'(npulse),        32'd3);
        chk("abort_bits",      32'(cap[2:0]),      32'h2);
        chk("abort_ndone",     32'(ndone),         32'd0);
        bus.start = 1'b1;
        cap_clr();
        src_q.push_back(8'hAA);
        drive_src();
        repeat (14) step();
        chk("resume_bits",   32'(cap[7:0]), 32'hAA);
        chk("resume_npulse", 32'(npulse),   32'd8);
        restart();

        // Reset mid-byte with the holding register full
        cap_clr();
        src_q.push_back(8'hF0);
        src_q.push_back(8'h0F);
        drive_src();
        repeat (6) step();
        chk("pre_rst_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        src_q.delete();
        drive_src();
        #1;
        chk("post_rst_sout",  32'(bus.serial_out),    32'h0);
        chk("post_rst_sen",   32'(bus.serial_en),     32'h0);
        chk("post_rst_done",  32'(bus.byte_done),     32'h0);
        chk("post_rst_under", 32'(bus.underrun),      32'h0);
        chk("post_rst_busy",  32'(bus.busy),          32'h0);
        chk("post_rst_ready", 32'(bus.data_in_ready), 32'h1);
        cap_clr();
        repeat (12) step();
        chk("post_rst_nobits", 32'(npulse), 32'd0);

        // Randomized traffic against the model
        for (int blk = 0; blk < 20; blk++) begin
            case ($urandom_range(0, 4))
                0: be_per = 0;
                1: be_per = 1;
                2: be_per = 2;
                3: be_per = 3;
                default: be_per = 5;
            endcase
            repeat (200) begin
                rst = ($urandom_range(0, 299) == 0);
                bus.start = ($urandom_range(0, 149) != 0);
                if (src_q.size() < 2 && $urandom_range(0, 3) != 0) src_q.push_back(8'($urandom));
                vgate = ($urandom_range(0, 4) != 0);
                drive_src();
                step();
            end
        end
        rst = 1'b0;
        bus.start = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/byte_p2s.md
Name: byte_p2s

Overview:
TX byte serializer: accepts parallel bytes over a valid/ready handshake and emits them MSB-first as a serial bitstream, one bit per asserted bit-rate strobe.
Each output bit is qualified by a one-cycle serial_en pulse.
A one-byte holding register in front of the shift register keeps consecutive bytes gap-free at any strobe rate.
Sits between the packet/byte source and the modulator bit path on the TX side.

Parameters:
none (byte width fixed at 8).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  conversion enable; low = synchronous flush/idle
data_in  input  8  byte to serialize
data_in_valid  input  1  data_in qualifier
data_in_ready  output  1  holding register can accept a byte this cycle
bit_en  input  1  bit-rate strobe; one serial bit per asserted cycle
serial_out  output  1  serialized data bit (registered)
serial_en  output  1  serial_out qualifier, one-cycle pulse per bit (registered)
byte_done  output  1  one-cycle pulse coincident with serial_en of a byte's 8th bit
underrun  output  1  sticky: strobe arrived with no data mid-stream
busy  output  1  high in SHIFT or while holding register full

Behaviour:
- Reset: rst=1 or start=0 at a clock edge clears all state.
  - state=IDLE, hold_full=0, shift reg=0, bitcnt=0, sent_any=0.
  - Outputs: serial_out=0, serial_en=0, byte_done=0, underrun=0.
  - rst has priority over all other inputs.
- Handshake:
  - data_in_ready = start & ~rst & ~hold_full (combinational).
  - Transfer occurs when data_in_valid & data_in_ready; hold <= data_in, hold_full <= 1.
  - data_in is ignored when not ready.
- FSM states: IDLE, SHIFT.
  - IDLE with hold_full=1: shreg <= hold, hold_full <= 0, bitcnt <= 0, go to SHIFT. The bit_en value that cycle is ignored.
  - SHIFT with bit_en=1: serial_out <= shreg[7], shreg <= shreg<<1, bitcnt <= bitcnt+1 (3-bit, wraps 7->0), serial_en <= 1.
  - SHIFT with bit_en=0: registers hold; serial_en <= 0.
  - SHIFT, bit_en=1, bitcnt==7: byte_done <= 1, sent_any <= 1.
    - If hold_full=1: load hold into shreg, clear hold_full, stay in SHIFT (seamless; next byte's MSB goes out on the next strobe).
    - If hold_full=0: go to IDLE.
- Latency:
  - Byte accepted at edge N (IDLE, empty) -> shreg loaded at N+1 -> first bit_en sampled at or after N+2 drives serial_out/serial_en on that edge.
  - serial_en is never high two consecutive cycles unless bit_en is high in consecutive cycles.
- Accept and reload in the same cycle cannot occur: ready requires hold empty, reload requires hold full.
  - The hold refills in the cycle after reload, so a continuous bit_en stream never starves if the source is ready within 7 cycles.
- Underrun:
  - Set when state=IDLE, hold_full=0, sent_any=1, start=1 and bit_en=1.
  - Stays set until rst or start=0.
  - No serial_en is produced in that case.
- serial_out holds its last value between pulses.
- busy = (state==SHIFT) | hold_full.
- start dropping mid-byte aborts immediately. The partial byte is discarded, no byte_done is issued, and the next edge shows serial_en=0.

Test Plan:
- Single byte 0xA5, bit_en every cycle -> serial_out on the 8 serial_en pulses = 1,0,1,0,0,1,0,1. byte_done on the 8th pulse only. busy drops the cycle after. underrun=0 while bit_en keeps toggling only if a new byte arrives; otherwise underrun=1 on the next strobe.
- Back-to-back 0x3C then 0xC3, bit_en every cycle, source always valid -> 16 consecutive serial_en cycles with no gap. Bits = 00111100 11000011. byte_done pulses at pulse 8 and 16.
- Byte 0x81 with bit_en every 4th cycle -> serial_en pulses exactly 4 cycles apart, bits 1,0,0,0,0,0,0,1. data_in_ready low from acceptance until the shreg load.
- Send 0xFF, then stop supplying data with bit_en still toggling -> underrun=1 on the first strobe after byte_done. It stays 1 until start=0, which clears it the next cycle.
- Byte 0x55, deassert start after 3 serial_en pulses -> serial_en=0 and busy=0 from the next cycle, no byte_done. Reasserting start with 0xAA then produces 1,0,1,0,1,0,1,0 from the MSB.
- Assert rst for 1 cycle mid-byte with hold_full=1 -> all outputs 0 and data_in_ready=1 (start high) the cycle after rst deasserts. No residual bits are emitted.
